seq_int_divider: RTL and testbench

Multi-cycle radix-2 restoring integer divider that acts as the responder side of the ALU start/done handshake. It is instantiated under the CPU's multi-cycle ALU and computes quotient and remainder together, signed or unsigned. A single `start` pulse launches an operation; a single-cycle `done` pulse reports the registered results.

---
 rtl/seq_int_divider.sv | 113 +++++++++++
 tb/tb_seq_int_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_int_divider.sv
// Multi-cycle radix-2 restoring divider (quotient + remainder, signed/unsigned) behind a start/done handshake.
// Optional IDIV_ZERO_FASTPATH_EN: a zero divisor bypasses the iteration loop (same results, 2-edge latency).
module seq_int_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] y_quotient,
  output logic [DATA_WIDTH-1:0] y_remainder,
  output logic                  done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [DATA_WIDTH-1:0]   rem;      // partial remainder
  logic [DATA_WIDTH-1:0]   dq;       // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0]   div_mag;
  logic                    neg_q;
  logic                    neg_r;

  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   rem_next;
  logic                    no_borrow;

  // Two's-complement magnitude; the most negative value maps onto itself as an unsigned number.
  assign a_mag = (is_signed && a[DATA_WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[DATA_WIDTH-1]) ? -b : b;

  // The shifted remainder is DATA_WIDTH+1 bits wide; its top bit is rem's MSB. When that bit is
  // set the subtraction always succeeds and the modulo-2^W difference is already the exact result.
  assign shifted   = {rem[DATA_WIDTH-2:0], dq[DATA_WIDTH-1]};
  assign no_borrow = rem[DATA_WIDTH-1] || (shifted >= div_mag);
  assign rem_next  = no_borrow ? (shifted - div_mag) : shifted;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      dq          <= '0;
      div_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      y_quotient  <= '0;
      y_remainder <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_mag <= b_mag;
            rem     <= '0;
            dq      <= a_mag;
            count   <= '0;
            neg_q   <= is_signed && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]) && (b != '0);
            neg_r   <= is_signed && a[DATA_WIDTH-1];
            busy    <= 1'b1;
`ifdef IDIV_ZERO_FASTPATH_EN
            // Preload what the full loop would produce for a zero divisor.
            if (b == '0) begin
              rem   <= a_mag;
              dq    <= '1;
              state <= FINISH;
            end else begin
              state <= DIVIDE;
            end
`else
            state   <= DIVIDE;
`endif
          end
        end

        DIVIDE: begin
          rem   <= rem_next;
          dq    <= {dq[DATA_WIDTH-2:0], no_borrow};
          count <= count + 1'b1;
          if (count == CNT_W'(DATA_WIDTH - 1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          y_quotient  <= neg_q ? -dq : dq;
          y_remainder <= neg_r ? -rem : rem;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_int_divider.sv
// Self-checking bench for seq_int_divider: directed corners, handshake and reset cases,
// then randomized operations against an arithmetic reference model.
module tb_seq_int_divider;

  localparam int W = 32;
`ifdef IDIV_ZERO_FASTPATH_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic [W-1:0] y_quotient;
  logic [W-1:0] y_remainder;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  seq_int_divider #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .y_quotient  (y_quotient),
    .y_remainder (y_remainder),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division computed in 64-bit arithmetic; a zero divisor yields all ones / raw dividend.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint la;
    longint lb;
    if (mb == '0) begin
      q = '1;
      r = ma;
    end else begin
      if (ms) begin
        la = longint'($signed(ma));
        lb = longint'($signed(mb));
      end else begin
        la = longint'({32'd0, ma});
        lb = longint'({32'd0, mb});
      end
      q = W'(la / lb);
      r = W'(la % lb);
    end
  endfunction

  // Launches one operation and waits (bounded) for done. lat is the edge offset of done from the
  // start edge, or -1 on timeout. inject > 0 re-pulses start with other operands at that offset.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                        input int inject, output int lat,
                        output logic [W-1:0] q, output logic [W-1:0] r);
    @(negedge clk);
    a = ra;
    b = rb;
    is_signed = rs;
    start = 1'b1;
    lat = -1;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = ~rs;
        check("busy_after_start", 64'(busy), 64'(1));
        check("done_low_after_start", 64'(done), 64'(0));
      end
      if (inject > 0 && e == inject) begin
        start = 1'b1;
        a = ~ra;
        b = rb + 32'd5;
      end
      if (inject > 0 && e == inject + 1) start = 1'b0;
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
    q = y_quotient;
    r = y_remainder;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic rs, input int inject);
    logic [W-1:0] eq, er, gq, gr;
    int lat, elat;
    model(ra, rb, rs, eq, er);
    elat = (rb == '0) ? ZERO_LAT : W + 1;
    run_op(ra, rb, rs, inject, lat, gq, gr);
    check({tag, "_quot"}, 64'(gq), 64'(eq));
    check({tag, "_rem"}, 64'(gr), 64'(er));
    check({tag, "_lat"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    logic         saw_done;
    int           sel;

    reset_n   = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    #1;
    check("reset_quot", 64'(y_quotient), 64'(0));
    check("reset_rem", 64'(y_remainder), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    do_op("u_100_7", 32'd100, 32'd7, 1'b0, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    do_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    do_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0);
    do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op("s_div0", 32'd1234, 32'd0, 1'b1, 0);
    do_op("u_div0", 32'd1234, 32'd0, 1'b0, 0);
    do_op("s_div0_neg", 32'hFFFF_F000, 32'd0, 1'b1, 0);

    // Start while busy is ignored
    do_op("ignored_start", 32'd1000, 32'd3, 1'b0, 5);

    // Back-to-back: second start is asserted during the done cycle of the first
    do_op("b2b_first", 32'd77, 32'd5, 1'b0, 0);
    do_op("b2b_second", 32'hFFFF_FFB3, 32'd5, 1'b1, 0);

    // Asynchronous reset in the middle of DIVIDE
    @(negedge clk);
    a = 32'd5000;
    b = 32'd9;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_quot", 64'(y_quotient), 64'(0));
    check("midrst_rem", 64'(y_remainder), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'(0));
    do_op("post_rst", 32'd5000, 32'd9, 1'b0, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      rb = '0;
      else if (sel < 3)  rb = $urandom_range(1, 20);
      else if (sel == 3) rb = -($urandom_range(1, 20));
      else               rb = $urandom;
      if (i % 5 == 0) ra = $urandom_range(0, 50);
      rs = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), ra, rb, rs, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
